// File: rtl/fb_wb_pkg.sv
// Shared widths, FSM encoding and payload types for the writeback arbiter.
package fb_wb_pkg;

    localparam int unsigned XLEN             = 32;
    localparam int unsigned REG_AW           = 5;
    localparam int unsigned NREGS            = 32;
    localparam int unsigned CNT_W            = 4;
    localparam int unsigned MAX_WAIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EX   = 2'd1,
        GNT_BUF  = 2'd2
    } grant_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_payload_t;

endpackage

// File: rtl/fb_scoreboard.sv
// Pending-destination scoreboard: tracks outstanding long-latency writes
// and raises the decode stall on RAW/WAW hazards or a pipeline freeze.
module fb_scoreboard
    import fb_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              clr_valid,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic              hold,
    output logic              dec_stall
);

    // Bit 0 is never set, so x0 can never look pending.
    logic [NREGS-1:0] pending_q, pending_d;
    logic [NREGS-1:0] set_mask, clr_mask;
    logic             rs1_busy, rs2_busy, waw;

    // Hazard detection; a source whose result drains this cycle is not a hazard,
    // but a WAW against a draining destination still stalls.
    always_comb begin
        rs1_busy  = (rs1 != '0) && pending_q[rs1] && !(clr_valid && (clr_rd == rs1));
        rs2_busy  = (rs2 != '0) && pending_q[rs2] && !(clr_valid && (clr_rd == rs2));
        waw       = issue_valid && pending_q[issue_rd];
        dec_stall = hold || rs1_busy || rs2_busy || waw;
    end

    // Next pending vector; set is applied after clear so it wins on a collision.
    always_comb begin
        set_mask  = '0;
        clr_mask  = '0;
        if (issue_valid && !dec_stall && (issue_rd != '0)) begin
            set_mask = NREGS'(1) << issue_rd;
        end
        if (clr_valid && (clr_rd != '0)) begin
            clr_mask = NREGS'(1) << clr_rd;
        end
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // Pending register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/fb_wb_arbiter.sv
// Register-file write-port arbiter between the single-cycle pipeline and a
// buffered long-latency result, with a starvation guard that freezes EX.
module fb_wb_arbiter
    import fb_wb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]   ex_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              dec_stall,
    output logic              ex_hold,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buf_valid_q, buf_valid_d;
    wb_payload_t      buf_q, buf_d;
    grant_e           grant;
    wb_payload_t      gnt_pl;
    logic             drain, accept, blocked;

    assign ex_hold   = (state_q == ST_HOLD);
    assign drain     = (grant == GNT_BUF);
    assign lsu_ready = !buf_valid_q || drain;
    assign accept    = lsu_valid && lsu_ready;
    assign blocked   = buf_valid_q && ex_valid && (state_q != ST_HOLD);

    // Write-port grant and payload mux; x0 writes are suppressed but the mux still follows.
    always_comb begin
        grant  = GNT_NONE;
        gnt_pl = '0;
        if (state_q == ST_HOLD) begin
            grant = GNT_BUF;
        end else if (ex_valid) begin
            grant = GNT_EX;
        end else if (buf_valid_q) begin
            grant = GNT_BUF;
        end
        case (grant)
            GNT_EX:  gnt_pl = '{rd: ex_rd, data: ex_data};
            GNT_BUF: gnt_pl = buf_q;
            default: gnt_pl = '0;
        endcase
        rf_we    = (grant != GNT_NONE) && (gnt_pl.rd != '0);
        rf_waddr = gnt_pl.rd;
        rf_wdata = gnt_pl.data;
    end

    // One-entry result buffer; a load in the drain cycle keeps results back-to-back.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_d       = '{rd: lsu_rd, data: lsu_data};
        end else if (drain) begin
            buf_valid_d = 1'b0;
        end
    end

    // Starvation FSM next state: count blocked cycles, then force one HOLD cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (blocked) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!blocked) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and buffer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

    fb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .clr_valid  (drain),
        .clr_rd     (buf_q.rd),
        .hold       (ex_hold),
        .dec_stall  (dec_stall)
    );

endmodule

// File: tb/tb_fb_wb_arbiter.sv
// Bench for fb_wb_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model (result queue, pending set, blocked-run count).
module tb_fb_wb_arbiter;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, lsu_valid, issue_valid;
    logic [4:0]  ex_rd, lsu_rd, issue_rd, rs1, rs2;
    logic [31:0] ex_data, lsu_data;
    logic        lsu_ready, dec_stall, ex_hold, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    fb_wb_arbiter #(.MAX_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .dec_stall  (dec_stall),
        .ex_hold    (ex_hold),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    int ncmp = 0;
    int nfail = 0;

    // Reference model state
    bit          m_pend [32];
    logic [4:0]  m_q_rd [$];
    logic [31:0] m_q_data [$];
    int          m_run;

    // Expected values for the current cycle
    bit          e_hold, e_ready, e_stall, e_we, e_drain, e_accept, e_set;
    int          e_src;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit busy(input logic [4:0] r);
        return (r != 0) && m_pend[r] && !(e_drain && m_q_rd[0] == r);
    endfunction

    task automatic model_eval();
        bit full;
        full   = (m_q_rd.size() != 0);
        e_hold = (m_run == int'(MW));
        if (e_hold)        e_src = 2;
        else if (ex_valid) e_src = 1;
        else if (full)     e_src = 2;
        else               e_src = 0;
        e_drain  = (e_src == 2);
        e_ready  = !full || e_drain;
        e_accept = lsu_valid && e_ready;
        e_rd     = (e_src == 1) ? ex_rd : (e_src == 2) ? m_q_rd[0] : 5'd0;
        e_data   = (e_src == 1) ? ex_data : (e_src == 2) ? m_q_data[0] : 32'd0;
        e_we     = (e_src != 0) && (e_rd != 0);
        e_stall  = e_hold || busy(rs1) || busy(rs2) || (issue_valid && m_pend[issue_rd]);
        e_set    = issue_valid && !e_stall && (issue_rd != 0);
    endtask

    task automatic model_commit();
        bit was_blocked;
        was_blocked = (m_q_rd.size() != 0) && ex_valid && !e_hold;
        if (e_drain) begin
            if (m_q_rd[0] != 0) m_pend[m_q_rd[0]] = 1'b0;
            void'(m_q_rd.pop_front());
            void'(m_q_data.pop_front());
        end
        if (e_set) m_pend[issue_rd] = 1'b1;
        if (e_accept) begin
            m_q_rd.push_back(lsu_rd);
            m_q_data.push_back(lsu_data);
        end
        if (e_hold)           m_run = 0;
        else if (was_blocked) m_run = m_run + 1;
        else                  m_run = 0;
    endtask

    task automatic model_clear();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_q_rd.delete();
        m_q_data.delete();
        m_run = 0;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    // Evaluate model after inputs settle and compare every output
    task automatic check_cycle(input string tag);
        #1;
        model_eval();
        chk({tag, ".ex_hold"},   32'(ex_hold),   32'(e_hold));
        chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(e_ready));
        chk({tag, ".dec_stall"}, 32'(dec_stall), 32'(e_stall));
        chk({tag, ".rf_we"},     32'(rf_we),     32'(e_we));
        if (e_src != 0) begin
            chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e_rd));
            chk({tag, ".rf_wdata"}, rf_wdata, e_data);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic hard_reset(input string tag);
        idle_inputs();
        reset = 1'b0;
        #1;
        model_clear();
        chk({tag, ".rst_lsu_ready"}, 32'(lsu_ready), 32'd1);
        chk({tag, ".rst_dec_stall"}, 32'(dec_stall), 32'd0);
        chk({tag, ".rst_ex_hold"},   32'(ex_hold),   32'd0);
        chk({tag, ".rst_rf_we"},     32'(rf_we),     32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int pex;
        idle_inputs();
        reset = 1'b1;
        model_clear();
        #2;
        hard_reset("init");

        // Single lsu result, written the cycle after acceptance, clears pending[5]
        issue_valid = 1; issue_rd = 5;
        check_cycle("r20_issue"); advance(); idle_inputs();
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'hA5A5A5A5; rs1 = 5;
        check_cycle("r20_acc");
        chk("r20_ready", 32'(lsu_ready), 32'd1);
        chk("r20_no_write_same_cycle", 32'(rf_we), 32'd0);
        advance(); idle_inputs(); rs1 = 5;
        check_cycle("r20_wr");
        chk("r20_we", 32'(rf_we), 32'd1);
        chk("r20_waddr", 32'(rf_waddr), 32'd5);
        chk("r20_wdata", rf_wdata, 32'hA5A5A5A5);
        chk("r20_stall_draining", 32'(dec_stall), 32'd0);
        advance(); idle_inputs(); rs1 = 5;
        check_cycle("r20_after");
        chk("r20_cleared", 32'(dec_stall), 32'd0);
        advance(); idle_inputs();

        // EX wins over buffered result; buffer drains at first idle cycle
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_7777;
        check_cycle("r21_load"); advance(); idle_inputs();
        ex_valid = 1; ex_rd = 3; ex_data = 32'h3333_0003;
        check_cycle("r21_ex");
        chk("r21_waddr_ex", 32'(rf_waddr), 32'd3);
        chk("r21_ready_low", 32'(lsu_ready), 32'd0);
        advance(); idle_inputs();
        check_cycle("r21_drain");
        chk("r21_waddr_buf", 32'(rf_waddr), 32'd7);
        chk("r21_wdata_buf", rf_wdata, 32'h0000_7777);
        advance(); idle_inputs();

        // Continuous EX with full buffer: hold on 5th cycle after load
        ex_valid = 1; ex_rd = 4; ex_data = 32'h4444_4444;
        lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC0DE_000C;
        check_cycle("r22_load"); advance(); lsu_valid = 0;
        for (int k = 1; k <= 5; k++) begin
            check_cycle("r22_run");
            chk("r22_hold", 32'(ex_hold), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                chk("r22_hold_waddr", 32'(rf_waddr), 32'd12);
                chk("r22_hold_stall", 32'(dec_stall), 32'd1);
            end
            advance();
        end
        check_cycle("r22_post");
        chk("r22_post_hold", 32'(ex_hold), 32'd0);
        chk("r22_post_waddr", 32'(rf_waddr), 32'd4);
        advance(); idle_inputs();

        // RAW stall on rd 9 until its drain cycle
        issue_valid = 1; issue_rd = 9;
        check_cycle("r23_issue"); advance(); idle_inputs();
        for (int k = 0; k < 3; k++) begin
            rs1 = 9;
            check_cycle("r23_wait");
            chk("r23_stall", 32'(dec_stall), 32'd1);
            advance();
        end
        rs1 = 9; lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9999_9999;
        check_cycle("r23_acc");
        chk("r23_stall_acc", 32'(dec_stall), 32'd1);
        advance(); idle_inputs(); rs1 = 9;
        check_cycle("r23_drain");
        chk("r23_stall_drain", 32'(dec_stall), 32'd0);
        chk("r23_waddr", 32'(rf_waddr), 32'd9);
        advance(); idle_inputs();

        // x0 destinations: no write, no pending bit
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD_0000;
        check_cycle("r24_lsu0"); advance(); idle_inputs();
        check_cycle("r24_drain0");
        chk("r24_lsu_we", 32'(rf_we), 32'd0);
        advance(); idle_inputs();
        ex_valid = 1; ex_rd = 0; ex_data = 32'h1234_5678;
        check_cycle("r24_ex0");
        chk("r24_ex_we", 32'(rf_we), 32'd0);
        chk("r24_ex_waddr", 32'(rf_waddr), 32'd0);
        advance(); idle_inputs();
        issue_valid = 1; issue_rd = 0;
        check_cycle("r24_iss0"); advance();
        check_cycle("r24_iss0_again");
        chk("r24_no_pending", 32'(dec_stall), 32'd0);
        advance(); idle_inputs();

        // Reset in HOLD with buffered result discards it
        ex_valid = 1; ex_rd = 6; ex_data = 32'h6666_6666;
        lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h2020_2020;
        check_cycle("r25_load"); advance(); lsu_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            check_cycle("r25_run"); advance();
        end
        check_cycle("r25_hold");
        chk("r25_in_hold", 32'(ex_hold), 32'd1);
        hard_reset("r25");
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            check_cycle("r25_after");
            chk("r25_no_write", 32'(rf_we), 32'd0);
            advance();
        end

        // Randomized traffic with alternating EX pressure
        for (int i = 0; i < 3000; i++) begin
            pex = ((i / 150) % 2 == 1) ? 92 : 40;
            ex_valid    = ($urandom_range(0, 99) < pex);
            ex_rd       = 5'($urandom_range(0, 7));
            ex_data     = $urandom;
            lsu_valid   = ($urandom_range(0, 99) < 45);
            lsu_rd      = 5'($urandom_range(0, 7));
            lsu_data    = $urandom;
            issue_valid = ($urandom_range(0, 99) < 30);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            check_cycle("rand");
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
